// File: rtl/branch_resolve_unit_if.sv
// Signal bundle between IF/EX and the branch resolve unit.
// The master drives fetch/resolve records; the slave (resolve unit) returns strobes and status.
interface branch_resolve_unit_if #(
    parameter int WORD_SIZE = 16,
    parameter int CNT_WIDTH = 16
);
    logic                 fetch_valid;
    logic [WORD_SIZE-1:0] fetch_pc;
    logic [WORD_SIZE-1:0] fetch_predicted_pc;
    logic                 fetch_tag_hit;
    logic                 resolve_valid;
    logic                 resolve_is_branch;
    logic                 resolve_taken;
    logic [WORD_SIZE-1:0] resolve_target;

    logic                 queue_full;
    logic                 flush;
    logic [WORD_SIZE-1:0] redirect_pc;
    logic                 update_tag;
    logic                 update_bht;
    logic                 bht_taken;
    logic [WORD_SIZE-1:0] pc_for_btb_update;
    logic [WORD_SIZE-1:0] branch_target_for_btb_update;
    logic                 branch_correct_or_notCorrect;
    logic [CNT_WIDTH-1:0] branch_count;
    logic [CNT_WIDTH-1:0] mispredict_count;
    logic                 overflow_err;
    logic                 underflow_err;

    modport master (
        output fetch_valid, fetch_pc, fetch_predicted_pc, fetch_tag_hit,
               resolve_valid, resolve_is_branch, resolve_taken, resolve_target,
        input  queue_full, flush, redirect_pc, update_tag, update_bht, bht_taken,
               pc_for_btb_update, branch_target_for_btb_update,
               branch_correct_or_notCorrect, branch_count, mispredict_count,
               overflow_err, underflow_err
    );

    modport slave (
        input  fetch_valid, fetch_pc, fetch_predicted_pc, fetch_tag_hit,
               resolve_valid, resolve_is_branch, resolve_taken, resolve_target,
        output queue_full, flush, redirect_pc, update_tag, update_bht, bht_taken,
               pc_for_btb_update, branch_target_for_btb_update,
               branch_correct_or_notCorrect, branch_count, mispredict_count,
               overflow_err, underflow_err
    );
endinterface

// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: in-order queue of fetched predictions, retired against EX results.
// Produces flush/redirect on mispredict and one-cycle BTB/BHT training strobes.
module branch_resolve_unit #(
    parameter int WORD_SIZE   = 16,
    parameter int QUEUE_DEPTH = 4,
    parameter int CNT_WIDTH   = 16
) (
    input  logic               clk,
    input  logic               reset,
    branch_resolve_unit_if.slave bus
);
    localparam int PTR_W = $clog2(QUEUE_DEPTH);
    localparam int OCC_W = PTR_W + 1;

    typedef logic [WORD_SIZE-1:0] word_t;
    typedef struct packed {
        word_t pc;
        word_t ppc;
        logic  hit;
    } entry_t;

    entry_t               mem_q [QUEUE_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q;
    logic [OCC_W-1:0]     occ_q;
    logic                 flush_q, update_tag_q, update_bht_q, bht_taken_q, correct_q;
    word_t                redirect_q, pc_upd_q, tgt_upd_q;
    logic [CNT_WIDTH-1:0] bcnt_q, mcnt_q;
    logic                 ovf_q, udf_q;

    logic   empty, full, pop, push_ok, taken_act, correct, mispredict;
    logic   update_tag_d, update_bht_d;
    entry_t head;
    word_t  actual;

    always_comb begin
        empty        = (occ_q == '0);
        full         = (occ_q == OCC_W'(QUEUE_DEPTH));
        head         = mem_q[rd_ptr_q];
        pop          = bus.resolve_valid && !empty;
        taken_act    = bus.resolve_is_branch && bus.resolve_taken;
        actual       = taken_act ? bus.resolve_target : word_t'(head.pc + word_t'(1));
        correct      = (head.ppc == actual);
        mispredict   = pop && !correct;
        // Pushes in the flush cycle or behind a mispredict are wrong-path.
        push_ok      = bus.fetch_valid && !flush_q && !mispredict && (!full || pop);
        update_tag_d = taken_act && (!head.hit || head.ppc != bus.resolve_target);
        update_bht_d = (bus.resolve_is_branch && (head.hit || update_tag_d)) ||
                       (!bus.resolve_is_branch && head.hit);
    end

    // Storage needs no reset: occupancy alone decides which slots are live.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= '{pc: bus.fetch_pc, ppc: bus.fetch_predicted_pc,
                                          hit: bus.fetch_tag_hit};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            occ_q        <= '0;
            flush_q      <= 1'b0;
            redirect_q   <= '0;
            update_tag_q <= 1'b0;
            update_bht_q <= 1'b0;
            bht_taken_q  <= 1'b0;
            pc_upd_q     <= '0;
            tgt_upd_q    <= '0;
            correct_q    <= 1'b0;
            bcnt_q       <= '0;
            mcnt_q       <= '0;
            ovf_q        <= 1'b0;
            udf_q        <= 1'b0;
        end else begin
            if (mispredict) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                occ_q    <= '0;
            end else begin
                if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
                if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
                if (push_ok && !pop)      occ_q <= occ_q + 1'b1;
                else if (!push_ok && pop) occ_q <= occ_q - 1'b1;
            end

            flush_q      <= mispredict;
            redirect_q   <= mispredict ? actual : '0;
            update_tag_q <= pop && update_tag_d;
            update_bht_q <= pop && update_bht_d;
            bht_taken_q  <= pop && taken_act;
            pc_upd_q     <= pop ? head.pc : '0;
            tgt_upd_q    <= pop ? bus.resolve_target : '0;
            correct_q    <= pop && correct;

            if (pop && bus.resolve_is_branch && bcnt_q != '1) bcnt_q <= bcnt_q + 1'b1;
            if (mispredict && mcnt_q != '1) mcnt_q <= mcnt_q + 1'b1;

            if (bus.fetch_valid && full && !pop) ovf_q <= 1'b1;
            if (bus.resolve_valid && empty && !push_ok) udf_q <= 1'b1;
        end
    end

    assign bus.queue_full                   = full;
    assign bus.flush                        = flush_q;
    assign bus.redirect_pc                  = redirect_q;
    assign bus.update_tag                   = update_tag_q;
    assign bus.update_bht                   = update_bht_q;
    assign bus.bht_taken                    = bht_taken_q;
    assign bus.pc_for_btb_update            = pc_upd_q;
    assign bus.branch_target_for_btb_update = tgt_upd_q;
    assign bus.branch_correct_or_notCorrect = correct_q;
    assign bus.branch_count                 = bcnt_q;
    assign bus.mispredict_count             = mcnt_q;
    assign bus.overflow_err                 = ovf_q;
    assign bus.underflow_err                = udf_q;
endmodule

// File: tb/tb_branch_resolve_unit.sv
module tb_branch_resolve_unit;
  localparam int WS = 16;
  localparam int QD = 4;
  localparam int CW = 6;

  typedef struct {
    logic [WS-1:0] pc;
    logic [WS-1:0] ppc;
    logic          hit;
  } rec_t;

  logic clk, reset;
  branch_resolve_unit_if #(.WORD_SIZE(WS), .CNT_WIDTH(CW)) bus ();

  branch_resolve_unit #(.WORD_SIZE(WS), .QUEUE_DEPTH(QD), .CNT_WIDTH(CW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  rec_t          mq[$];
  logic [CW-1:0] m_bcnt, m_mcnt;
  logic          m_ovf, m_udf, m_flush;
  logic          e_flush, e_ut, e_ub, e_bt, e_corr;
  logic [WS-1:0] e_redir, e_pc, e_tgt;

  task automatic chk(input string tag, input logic [WS-1:0] obs, input logic [WS-1:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_bcnt = '0; m_mcnt = '0; m_ovf = 0; m_udf = 0; m_flush = 0;
    e_flush = 0; e_ut = 0; e_ub = 0; e_bt = 0; e_corr = 0;
    e_redir = '0; e_pc = '0; e_tgt = '0;
  endtask

  task automatic check_all();
    logic qf;
    qf = (mq.size() == QD);
    chk("queue_full", bus.queue_full, qf);
    chk("flush", bus.flush, e_flush);
    chk("redirect_pc", bus.redirect_pc, e_redir);
    chk("update_tag", bus.update_tag, e_ut);
    chk("update_bht", bus.update_bht, e_ub);
    chk("bht_taken", bus.bht_taken, e_bt);
    chk("pc_for_btb_update", bus.pc_for_btb_update, e_pc);
    chk("target_for_btb_update", bus.branch_target_for_btb_update, e_tgt);
    chk("branch_correct", bus.branch_correct_or_notCorrect, e_corr);
    chk("branch_count", bus.branch_count, m_bcnt);
    chk("mispredict_count", bus.mispredict_count, m_mcnt);
    chk("overflow_err", bus.overflow_err, m_ovf);
    chk("underflow_err", bus.underflow_err, m_udf);
  endtask

  task automatic step(input logic fv, input logic [WS-1:0] fpc, input logic [WS-1:0] fppc,
                      input logic fhit, input logic rv, input logic isb, input logic tk,
                      input logic [WS-1:0] tgt);
    int   sz;
    logic full, pop, mis;
    rec_t h;
    logic [WS-1:0] act;
    bus.fetch_valid = fv; bus.fetch_pc = fpc; bus.fetch_predicted_pc = fppc;
    bus.fetch_tag_hit = fhit; bus.resolve_valid = rv; bus.resolve_is_branch = isb;
    bus.resolve_taken = tk; bus.resolve_target = tgt;

    sz   = mq.size();
    full = (sz == QD);
    pop  = rv && (sz > 0);
    mis  = 0;
    e_flush = 0; e_ut = 0; e_ub = 0; e_bt = 0; e_corr = 0;
    e_redir = '0; e_pc = '0; e_tgt = '0;
    if (pop) begin
      h      = mq[0];
      act    = (isb && tk) ? tgt : h.pc + 16'd1;
      e_corr = (h.ppc == act);
      e_pc   = h.pc;
      e_tgt  = tgt;
      e_bt   = isb && tk;
      e_ut   = isb && tk && (!h.hit || h.ppc != tgt);
      e_ub   = isb ? (h.hit || e_ut) : h.hit;
      if (!e_corr) begin
        mis = 1; e_flush = 1; e_redir = act;
        if (m_mcnt != '1) m_mcnt = m_mcnt + 1'b1;
      end
      if (isb && m_bcnt != '1) m_bcnt = m_bcnt + 1'b1;
    end
    if (rv && sz == 0 && !(fv && !m_flush)) m_udf = 1;
    if (fv && full && !pop) m_ovf = 1;
    if (mis) mq.delete();
    else begin
      if (pop) void'(mq.pop_front());
      if (fv && !m_flush && (!full || pop)) mq.push_back('{fpc, fppc, fhit});
    end
    m_flush = mis;

    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic push(input logic [WS-1:0] pc, input logic [WS-1:0] ppc, input logic hit);
    step(1, pc, ppc, hit, 0, 0, 0, '0);
  endtask

  task automatic resolve(input logic isb, input logic tk, input logic [WS-1:0] tgt);
    step(0, '0, '0, 0, 1, isb, tk, tgt);
  endtask

  task automatic idle();
    step(0, '0, '0, 0, 0, 0, 0, '0);
  endtask

  initial begin
    logic fv, rv, isb, tk, hit;
    logic [WS-1:0] pc, ppc, tgt;
    reset = 1'b1;
    bus.fetch_valid = 0; bus.fetch_pc = '0; bus.fetch_predicted_pc = '0; bus.fetch_tag_hit = 0;
    bus.resolve_valid = 0; bus.resolve_is_branch = 0; bus.resolve_taken = 0; bus.resolve_target = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    reset = 1'b0;

    push(16'h0100, 16'h0101, 0);
    push(16'h0102, 16'h0103, 1);
    push(16'h0104, 16'h0105, 0);
    #2 reset = 1'b1;
    model_reset();
    #1 check_all();
    #2 reset = 1'b0;
    resolve(0, 0, '0);
    chk("underflow_after_reset", bus.underflow_err, 1'b1);

    push(16'h0010, 16'h0011, 0);
    resolve(0, 0, 16'h0000);
    chk("nonbranch_correct", bus.branch_correct_or_notCorrect, 1'b1);
    chk("nonbranch_noflush", bus.flush, 1'b0);

    push(16'h0020, 16'h0021, 0);
    push(16'h0022, 16'h0023, 0);
    resolve(1, 1, 16'h0040);
    chk("taken_flush", bus.flush, 1'b1);
    chk("taken_redirect", bus.redirect_pc, 16'h0040);
    chk("taken_update_tag", bus.update_tag, 1'b1);
    chk("taken_update_bht", bus.update_bht, 1'b1);
    chk("taken_bht_taken", bus.bht_taken, 1'b1);
    chk("taken_pc_upd", bus.pc_for_btb_update, 16'h0020);
    chk("taken_mcount", bus.mispredict_count, 6'd1);
    push(16'h0077, 16'h0078, 0);
    chk("flush_is_pulse", bus.flush, 1'b0);

    push(16'h0030, 16'h0050, 1);
    resolve(1, 0, 16'h0050);
    chk("nt_flush", bus.flush, 1'b1);
    chk("nt_redirect", bus.redirect_pc, 16'h0031);
    chk("nt_update_tag", bus.update_tag, 1'b0);
    chk("nt_update_bht", bus.update_bht, 1'b1);
    chk("nt_bht_taken", bus.bht_taken, 1'b0);
    idle();

    for (int i = 0; i < QD; i++) push(16'h0200 + 16'(2 * i), 16'h0201 + 16'(2 * i), 0);
    push(16'h0300, 16'h0301, 0);
    chk("full_flag", bus.queue_full, 1'b1);
    chk("overflow_set", bus.overflow_err, 1'b1);
    step(1, 16'h0400, 16'h0401, 0, 1, 0, 0, '0);
    chk("full_after_pushpop", bus.queue_full, 1'b1);
    chk("fifo_head", bus.pc_for_btb_update, 16'h0200);
    for (int i = 0; i < QD; i++) resolve(0, 0, '0);
    chk("fifo_tail", bus.pc_for_btb_update, 16'h0400);

    for (int i = 0; i < 70; i++) begin
      push(16'h0500 + 16'(i), 16'h0600, 0);
      resolve(1, 0, 16'h0600);
      idle();
    end
    chk("mcount_saturated", bus.mispredict_count, 6'h3F);
    chk("bcount_saturated", bus.branch_count, 6'h3F);

    reset = 1'b1;
    model_reset();
    #1 check_all();
    #2 reset = 1'b0;
    for (int i = 0; i < 500; i++) begin
      fv  = ($urandom_range(0, 99) < 55);
      rv  = ($urandom_range(0, 99) < 45);
      isb = $urandom_range(0, 1);
      tk  = $urandom_range(0, 1);
      hit = $urandom_range(0, 1);
      pc  = 16'($urandom);
      if (i % 97 == 5) pc = 16'hFFFF;
      tgt = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'h0040;
      case ($urandom_range(0, 3))
        0, 1:    ppc = pc + 16'd1;
        2:       ppc = 16'h0040;
        default: ppc = 16'($urandom);
      endcase
      if (rv && mq.size() == 0) fv = 0;
      step(fv, pc, ppc, hit, rv, isb, tk, tgt);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
